// File: rtl/multi_blob_corner_tracker.sv
// ============================================================================
// Module  : multi_blob_corner_tracker
// Brief   : Per-pixel chroma classifier with temporal vote and per-channel
//           quadrilateral corner tracker; optional CORNER_SMOOTH_EN averaging.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_blob_corner_tracker #(
  parameter int NUM_CH     = 2,
  parameter int COORD_W    = 10,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int HIST_LEN   = 4,
  parameter int ADDR_W     = 19,
  parameter int CNT_W      = 16,
  parameter int MIN_PIXELS = 64,
  parameter int RD_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         VGA_VS,
  input  logic                         pix_valid,
  input  logic [7:0]                   Cb,
  input  logic [7:0]                   Cr,
  input  logic [COORD_W-1:0]           read_x,
  input  logic [COORD_W-1:0]           read_y,
  input  logic [ADDR_W-1:0]            read_addr,
  input  logic [NUM_CH*HIST_LEN-1:0]   hist_in,
  input  logic [NUM_CH*8-1:0]          cb_lo,
  input  logic [NUM_CH*8-1:0]          cb_hi,
  input  logic [NUM_CH*8-1:0]          cr_lo,
  input  logic [NUM_CH*8-1:0]          cr_hi,
  input  logic [2:0]                   threshold_history,
  input  logic [7:0]                   threshold_x_diff,
  input  logic [7:0]                   threshold_y_diff,
  input  logic [RD_W-1:0]              rd_ch,
  output logic [NUM_CH*HIST_LEN-1:0]   hist_out,
  output logic                         we,
  output logic [ADDR_W-1:0]            write_addr,
  output logic [NUM_CH*3-1:0]          corner_tag,
  output logic                         results_valid,
  output logic [8*COORD_W-1:0]         rd_corners,
  output logic [CNT_W-1:0]             rd_count,
  output logic                         rd_blob_valid
);

  localparam int c_TLX = 7, c_TLY = 6, c_TRX = 5, c_TRY = 4;
  localparam int c_BLX = 3, c_BLY = 2, c_BRX = 1, c_BRY = 0;
  localparam logic [COORD_W-1:0] c_X_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] c_Y_LAST = COORD_W'(V_RES - 1);
  localparam logic [CNT_W-1:0]   c_MIN    = CNT_W'(MIN_PIXELS);

  typedef enum logic [1:0] {ST_ACCUM = 2'd0, ST_LATCH = 2'd1, ST_PUBLISH = 2'd2} state_t;

  state_t                     r_state;
  logic                       r_vs_d1, r_vs_d2;
  logic [COORD_W-1:0]         r_xmax [NUM_CH];
  logic [COORD_W-1:0]         r_xmin [NUM_CH];
  logic [COORD_W-1:0]         r_ymax [NUM_CH];
  logic [COORD_W-1:0]         r_ymin [NUM_CH];
  logic [7:0][COORD_W-1:0]    r_trk  [NUM_CH];
  logic [7:0][COORD_W-1:0]    r_pub  [NUM_CH];
  logic [CNT_W-1:0]           r_cnt  [NUM_CH];
  logic [CNT_W-1:0]           r_pcnt [NUM_CH];
  logic [NUM_CH*HIST_LEN-1:0] r_hist;
  logic                       r_we, r_rv, r_rd_blob;
  logic [ADDR_W-1:0]          r_waddr;
  logic [NUM_CH*3-1:0]        r_tag;
  logic [8*COORD_W-1:0]       r_rd_corners;
  logic [CNT_W-1:0]           r_rd_count;

  logic [NUM_CH-1:0]          w_match, w_accept, w_acc_en;
  logic [NUM_CH*HIST_LEN-1:0] w_hist_nxt;
  logic [NUM_CH*3-1:0]        w_tag;
  logic [7:0][COORD_W-1:0]    w_cand [NUM_CH];
  logic [7:0][COORD_W-1:0]    w_pub_next [NUM_CH];
  logic                       w_vs_fall;
`ifdef CORNER_SMOOTH_EN
  logic [NUM_CH-1:0]          r_loaded;
  logic [COORD_W:0]           w_sum;
`endif

  function automatic logic [7:0] popcnt(input logic [HIST_LEN-1:0] v);
    logic [7:0] n;
    n = 8'd0;
    for (int i = 0; i < HIST_LEN; i++) n = n + 8'(v[i]);
    return n;
  endfunction

  function automatic logic [COORD_W-1:0] absd(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign w_vs_fall = r_vs_d2 & ~r_vs_d1;

  always_comb begin
    w_hist_nxt = '0;
    w_tag      = '0;
    w_match    = '0;
    w_accept   = '0;
    w_acc_en   = '0;
`ifdef CORNER_SMOOTH_EN
    w_sum      = '0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      w_match[c]  = (Cb >= cb_lo[c*8 +: 8]) && (Cb <= cb_hi[c*8 +: 8]) &&
                    (Cr >= cr_lo[c*8 +: 8]) && (Cr <= cr_hi[c*8 +: 8]);
      w_accept[c] = w_match[c] && (popcnt(hist_in[c*HIST_LEN +: HIST_LEN]) > {5'd0, threshold_history});
      w_acc_en[c] = w_accept[c] && pix_valid && (read_x <= c_X_LAST) && (read_y <= c_Y_LAST);
      w_hist_nxt[c*HIST_LEN +: HIST_LEN] = {hist_in[c*HIST_LEN +: HIST_LEN-1], w_match[c]};
      if (w_accept[c]) begin
        if (read_x == r_pub[c][c_TLX] && read_y == r_pub[c][c_TLY])      w_tag[c*3 +: 3] = 3'd1;
        else if (read_x == r_pub[c][c_TRX] && read_y == r_pub[c][c_TRY]) w_tag[c*3 +: 3] = 3'd2;
        else if (read_x == r_pub[c][c_BLX] && read_y == r_pub[c][c_BLY]) w_tag[c*3 +: 3] = 3'd3;
        else if (read_x == r_pub[c][c_BRX] && read_y == r_pub[c][c_BRY]) w_tag[c*3 +: 3] = 3'd4;
        else                                                             w_tag[c*3 +: 3] = 3'd5;
      end
      // Collapse rules are evaluated in order on the running candidate set.
      w_cand[c] = r_trk[c];
      if (absd(w_cand[c][c_TLY], w_cand[c][c_TRY]) <= COORD_W'(threshold_y_diff)) begin
        w_cand[c][c_TLX] = r_xmin[c]; w_cand[c][c_TLY] = r_ymin[c];
        w_cand[c][c_TRX] = r_xmax[c]; w_cand[c][c_TRY] = r_ymin[c];
      end
      if (absd(w_cand[c][c_TLX], w_cand[c][c_BLX]) <= COORD_W'(threshold_x_diff)) begin
        w_cand[c][c_TLX] = r_xmin[c]; w_cand[c][c_TLY] = r_ymin[c];
        w_cand[c][c_BLX] = r_xmin[c]; w_cand[c][c_BLY] = r_ymax[c];
      end
      if (absd(w_cand[c][c_BLY], w_cand[c][c_BRY]) <= COORD_W'(threshold_y_diff)) begin
        w_cand[c][c_BLX] = r_xmin[c]; w_cand[c][c_BLY] = r_ymax[c];
        w_cand[c][c_BRX] = r_xmax[c]; w_cand[c][c_BRY] = r_ymax[c];
      end
      if (absd(w_cand[c][c_TRX], w_cand[c][c_BRX]) <= COORD_W'(threshold_x_diff)) begin
        w_cand[c][c_TRX] = r_xmax[c]; w_cand[c][c_TRY] = r_ymin[c];
        w_cand[c][c_BRX] = r_xmax[c]; w_cand[c][c_BRY] = r_ymax[c];
      end
`ifdef CORNER_SMOOTH_EN
      for (int k = 0; k < 8; k++) begin
        w_sum = {1'b0, r_pub[c][k]} + {1'b0, w_cand[c][k]} + (COORD_W+1)'(1);
        w_pub_next[c][k] = r_loaded[c] ? w_sum[COORD_W:1] : w_cand[c][k];
      end
`else
      w_pub_next[c] = w_cand[c];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist  <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_tag   <= '0;
    end else begin
      r_hist  <= w_hist_nxt;
      r_we    <= pix_valid;
      r_waddr <= read_addr;
      r_tag   <= pix_valid ? w_tag : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_ACCUM;
      r_vs_d1 <= 1'b0;
      r_vs_d2 <= 1'b0;
      r_rv    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_xmax[c] <= '0;       r_xmin[c] <= c_X_LAST;
        r_ymax[c] <= '0;       r_ymin[c] <= c_Y_LAST;
        r_trk[c]  <= '0;       r_pub[c]  <= '0;
        r_cnt[c]  <= '0;       r_pcnt[c] <= '0;
      end
`ifdef CORNER_SMOOTH_EN
      r_loaded <= '0;
`endif
    end else begin
      r_vs_d1 <= VGA_VS;
      r_vs_d2 <= r_vs_d1;
      r_rv    <= 1'b0;
      case (r_state)
        ST_ACCUM: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (w_acc_en[c]) begin
              if (read_x >= r_xmax[c]) begin
                r_xmax[c] <= read_x; r_trk[c][c_BRX] <= read_x; r_trk[c][c_BRY] <= read_y;
              end
              if (read_x <= r_xmin[c]) begin
                r_xmin[c] <= read_x; r_trk[c][c_TLX] <= read_x; r_trk[c][c_TLY] <= read_y;
              end
              if (read_y >= r_ymax[c]) begin
                r_ymax[c] <= read_y; r_trk[c][c_BLX] <= read_x; r_trk[c][c_BLY] <= read_y;
              end
              if (read_y <= r_ymin[c]) begin
                r_ymin[c] <= read_y; r_trk[c][c_TRX] <= read_x; r_trk[c][c_TRY] <= read_y;
              end
              if (r_cnt[c] != {CNT_W{1'b1}}) r_cnt[c] <= r_cnt[c] + CNT_W'(1);
            end
          end
          if (w_vs_fall) r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          for (int c = 0; c < NUM_CH; c++) begin
            r_pcnt[c] <= r_cnt[c];
            if (r_cnt[c] >= c_MIN) begin
              r_pub[c] <= w_pub_next[c];
`ifdef CORNER_SMOOTH_EN
              r_loaded[c] <= 1'b1;
`endif
            end
          end
          r_rv    <= 1'b1;
          r_state <= ST_PUBLISH;
        end
        ST_PUBLISH: begin
          for (int c = 0; c < NUM_CH; c++) begin
            r_xmax[c] <= '0;       r_xmin[c] <= c_X_LAST;
            r_ymax[c] <= '0;       r_ymin[c] <= c_Y_LAST;
            r_trk[c]  <= '0;       r_cnt[c]  <= '0;
          end
          r_state <= ST_ACCUM;
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_corners <= '0;
      r_rd_count   <= '0;
      r_rd_blob    <= 1'b0;
    end else begin
      r_rd_corners <= r_pub[rd_ch];
      r_rd_count   <= r_pcnt[rd_ch];
      r_rd_blob    <= (r_pcnt[rd_ch] >= c_MIN);
    end
  end

  assign hist_out      = r_hist;
  assign we            = r_we;
  assign write_addr    = r_waddr;
  assign corner_tag    = r_tag;
  assign results_valid = r_rv;
  assign rd_corners    = r_rd_corners;
  assign rd_count      = r_rd_count;
  assign rd_blob_valid = r_rd_blob;

endmodule

`default_nettype wire

// File: tb/tb_multi_blob_corner_tracker.sv
// ============================================================================
// Module  : tb_multi_blob_corner_tracker
// Brief   : Directed, table-driven self-checking bench for the corner tracker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_blob_corner_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        VGA_VS = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  Cb = 8'd0, Cr = 8'd0;
  logic [9:0]  read_x = 10'd0, read_y = 10'd0;
  logic [18:0] read_addr = 19'd0;
  logic [7:0]  hist_in = 8'hFF;
  logic [15:0] cb_lo = {8'd100, 8'd0}, cb_hi = {8'd150, 8'd60};
  logic [15:0] cr_lo = {8'd100, 8'd0}, cr_hi = {8'd150, 8'd60};
  logic [2:0]  threshold_history = 3'd2;
  logic [7:0]  threshold_x_diff = 8'd10, threshold_y_diff = 8'd10;
  logic [0:0]  rd_ch = 1'b0;
  logic [7:0]  hist_out;
  logic        we;
  logic [18:0] write_addr;
  logic [5:0]  corner_tag;
  logic        results_valid;
  logic [79:0] rd_corners;
  logic [15:0] rd_count;
  logic        rd_blob_valid;

  int n_checks = 0;
  int n_errors = 0;

  multi_blob_corner_tracker dut (
    .clk(clk), .reset(reset), .VGA_VS(VGA_VS), .pix_valid(pix_valid),
    .Cb(Cb), .Cr(Cr), .read_x(read_x), .read_y(read_y), .read_addr(read_addr),
    .hist_in(hist_in), .cb_lo(cb_lo), .cb_hi(cb_hi), .cr_lo(cr_lo), .cr_hi(cr_hi),
    .threshold_history(threshold_history), .threshold_x_diff(threshold_x_diff),
    .threshold_y_diff(threshold_y_diff), .rd_ch(rd_ch), .hist_out(hist_out),
    .we(we), .write_addr(write_addr), .corner_tag(corner_tag),
    .results_valid(results_valid), .rd_corners(rd_corners), .rd_count(rd_count),
    .rd_blob_valid(rd_blob_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [9:0]  x, y;
    logic [7:0]  cb, cr, hist;
    logic [18:0] addr;
    logic [7:0]  e_hist;
    logic        e_we;
    logic [5:0]  e_tag;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_pixel(input int x, input int y, input logic [7:0] cv);
    pix_valid = 1'b1;
    read_x = 10'(x); read_y = 10'(y);
    Cb = cv; Cr = cv; hist_in = 8'hFF;
    @(negedge clk);
  endtask

  task automatic square(input int x0, input int y0);
    for (int y = y0; y < y0 + 10; y++)
      for (int x = x0; x < x0 + 10; x++) send_pixel(x, y, 8'd30);
    pix_valid = 1'b0;
  endtask

  task automatic end_frame();
    int seen;
    seen = 0;
    pix_valid = 1'b0;
    VGA_VS = 1'b1;
    repeat (3) @(negedge clk);
    VGA_VS = 1'b0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (results_valid) seen = 1;
    end
    check("results_valid_pulse", 128'(seen), 128'd1);
    @(negedge clk);
    check("results_valid_one_cycle", 128'(results_valid), 128'd0);
  endtask

  task automatic readout(input logic ch, input logic [79:0] e_c, input int e_cnt, input logic e_bv);
    rd_ch = ch;
    @(negedge clk);
    check("rd_corners", 128'(rd_corners), 128'(e_c));
    check("rd_count", 128'(rd_count), 128'(e_cnt));
    check("rd_blob_valid", 128'(rd_blob_valid), 128'(e_bv));
  endtask

  function automatic logic [79:0] pack(input int a, b, c, d, e, f, g, h);
    return {10'(a), 10'(b), 10'(c), 10'(d), 10'(e), 10'(f), 10'(g), 10'(h)};
  endfunction

  initial begin
    logic [79:0] sq_c, dm_c;
    int dy, seen_rv, exp_tlx;
    sq_c = pack(100, 200, 109, 200, 100, 209, 109, 209);
    dm_c = pack(300, 240, 320, 220, 320, 260, 340, 240);

    // Pixel-path vectors applied after the square frame is published on ch0.
    vecs[0] = '{1'b1, 10'd100, 10'd200, 8'd30, 8'd30, 8'hFF, 19'h00011, 8'hEF, 1'b1, 6'o01};
    vecs[1] = '{1'b1, 10'd109, 10'd200, 8'd30, 8'd30, 8'hFF, 19'h00022, 8'hEF, 1'b1, 6'o02};
    vecs[2] = '{1'b1, 10'd100, 10'd209, 8'd30, 8'd30, 8'hFF, 19'h00033, 8'hEF, 1'b1, 6'o03};
    vecs[3] = '{1'b1, 10'd109, 10'd209, 8'd30, 8'd30, 8'hFF, 19'h00044, 8'hEF, 1'b1, 6'o04};
    vecs[4] = '{1'b1, 10'd105, 10'd205, 8'd30, 8'd30, 8'hFF, 19'h7FFFF, 8'hEF, 1'b1, 6'o05};
    vecs[5] = '{1'b1, 10'd100, 10'd200, 8'd30, 8'd30, 8'hF3, 19'h12345, 8'hE7, 1'b1, 6'o00};
    vecs[6] = '{1'b0, 10'd100, 10'd200, 8'd30, 8'd30, 8'hFF, 19'h00055, 8'hEF, 1'b0, 6'o00};
    vecs[7] = '{1'b1, 10'd105, 10'd205, 8'd70, 8'd30, 8'hFF, 19'h00066, 8'hEE, 1'b1, 6'o00};
    vecs[8] = '{1'b1, 10'd700, 10'd5,   8'd120, 8'd120, 8'hFF, 19'h00077, 8'hFE, 1'b1, 6'o50};

    pix_valid = 1'b1; read_addr = 19'h1ABCD; Cb = 8'd30; Cr = 8'd30;
    repeat (3) @(negedge clk);
    check("reset_hist_out", 128'(hist_out), 128'd0);
    check("reset_we", 128'(we), 128'd0);
    check("reset_write_addr", 128'(write_addr), 128'd0);
    check("reset_corner_tag", 128'(corner_tag), 128'd0);
    check("reset_results_valid", 128'(results_valid), 128'd0);
    check("reset_rd_corners", 128'(rd_corners), 128'd0);
    check("reset_rd_count", 128'(rd_count), 128'd0);
    check("reset_rd_blob_valid", 128'(rd_blob_valid), 128'd0);
    pix_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    end_frame();
    readout(1'b0, 80'd0, 0, 1'b0);

    square(100, 200);
    end_frame();
    readout(1'b0, sq_c, 100, 1'b1);

    foreach (vecs[i]) begin
      pix_valid = vecs[i].pv; read_x = vecs[i].x; read_y = vecs[i].y;
      Cb = vecs[i].cb; Cr = vecs[i].cr; hist_in = vecs[i].hist; read_addr = vecs[i].addr;
      @(negedge clk);
      check($sformatf("vec%0d_we", i), 128'(we), 128'(vecs[i].e_we));
      check($sformatf("vec%0d_tag", i), 128'(corner_tag), 128'(vecs[i].e_tag));
      if (vecs[i].pv) begin
        check($sformatf("vec%0d_hist", i), 128'(hist_out), 128'(vecs[i].e_hist));
        check($sformatf("vec%0d_waddr", i), 128'(write_addr), 128'(vecs[i].addr));
      end
    end
    pix_valid = 1'b0;

    threshold_x_diff = 8'd5; threshold_y_diff = 8'd5;
    for (int y = 220; y <= 260; y++) begin
      dy = (y >= 240) ? y - 240 : 240 - y;
      for (int x = 320 - (20 - dy); x <= 320 + (20 - dy); x++) send_pixel(x, y, 8'd120);
    end
    pix_valid = 1'b0;
    end_frame();
    readout(1'b1, dm_c, 841, 1'b1);
    readout(1'b0, sq_c, 5, 1'b0);

    send_pixel(320, 220, 8'd120);
    pix_valid = 1'b0;
    check("diamond_tr_tag", 128'(corner_tag), 128'(6'o20));
    for (int x = 10; x < 40; x++) send_pixel(x, 50, 8'd30);
    pix_valid = 1'b0;
    end_frame();
    readout(1'b0, sq_c, 30, 1'b0);
    readout(1'b1, dm_c, 1, 1'b0);

    for (int x = 0; x < 5; x++) send_pixel(x, 0, 8'd30);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_rd_count", 128'(rd_count), 128'd0);
    check("midreset_rd_corners", 128'(rd_corners), 128'd0);
    check("midreset_corner_tag", 128'(corner_tag), 128'd0);
    pix_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen_rv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (results_valid) seen_rv = 1;
    end
    check("midreset_no_results_valid", 128'(seen_rv), 128'd0);

    threshold_x_diff = 8'd10; threshold_y_diff = 8'd10;
    square(100, 200);
    end_frame();
    rd_ch = 1'b0;
    @(negedge clk);
    check("smooth_first_tl_x", 128'(rd_corners[79:70]), 128'd100);
    square(111, 200);
    end_frame();
    rd_ch = 1'b0;
    @(negedge clk);
`ifdef CORNER_SMOOTH_EN
    exp_tlx = 106;
`else
    exp_tlx = 111;
`endif
    check("second_tl_x", 128'(rd_corners[79:70]), 128'(exp_tlx));
    check("second_tl_y", 128'(rd_corners[69:60]), 128'd200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
